issue_stage: RTL and testbench

ISSUE_STAGE -- requirements
Module: issue_stage

---
 rtl/issue_stage.sv | 146 ++++++++++++++
 tb/tb_issue_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - decode/issue stage: operand select, hazard stall, registered EXE slot.
// Optional ALU result forwarding is enabled with the ISSUE_FWD_EN macro.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

module issue_stage (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr,
  input  logic                    instr_valid,
  output logic                    stall,
  output logic [4:0]              rs_addr,
  output logic [4:0]              rt_addr,
  input  logic [31:0]             rs_data,
  input  logic [31:0]             rt_data,
  input  logic                    flush,
`ifdef ISSUE_FWD_EN
  input  logic [`WORD_LEN-1:0]    alu_fwd,
`endif
  output logic                    exe_valid,
  output logic [`EXE_CMD_LEN-1:0] exe_cmd,
  output logic [`WORD_LEN-1:0]    val1,
  output logic [`WORD_LEN-1:0]    val2,
  output logic [`WORD_LEN-1:0]    st_val,
  output logic [4:0]              dest,
  output logic                    wb_en,
  output logic                    mem_r_en,
  output logic                    mem_w_en,
  output logic                    illegal
);

  localparam logic [`EXE_CMD_LEN-1:0] EXE_ADD = 4'd1;
  localparam logic [`EXE_CMD_LEN-1:0] EXE_SUB = 4'd2;
  localparam logic [`EXE_CMD_LEN-1:0] EXE_AND = 4'd3;
  localparam logic [`EXE_CMD_LEN-1:0] EXE_OR  = 4'd4;
  localparam logic [`EXE_CMD_LEN-1:0] EXE_XOR = 4'd5;
  localparam logic [`EXE_CMD_LEN-1:0] EXE_NOR = 4'd6;

  logic [5:0]  opcode, funct;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rs_addr      = instr[25:21];
  assign rt_addr      = instr[20:16];
  assign rd           = instr[15:11];
  assign imm          = instr[15:0];
  assign unused_shamt = ^instr[10:6];

  logic                    legal, imm_op, sext, dec_wb, dec_mr, dec_mw, uses_rt;
  logic [`EXE_CMD_LEN-1:0] cmd;
  logic [4:0]              dec_dest;

  always_comb begin
    legal    = 1'b0;
    cmd      = EXE_ADD;
    imm_op   = 1'b1;
    sext     = 1'b1;
    dec_dest = rt_addr;
    dec_wb   = 1'b1;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    uses_rt  = 1'b0;
    case (opcode)
      6'h00: begin
        imm_op   = 1'b0;
        dec_dest = rd;
        uses_rt  = 1'b1;
        legal    = 1'b1;
        case (funct)
          6'h20:   cmd = EXE_ADD;
          6'h22:   cmd = EXE_SUB;
          6'h24:   cmd = EXE_AND;
          6'h25:   cmd = EXE_OR;
          6'h26:   cmd = EXE_XOR;
          6'h27:   cmd = EXE_NOR;
          default: legal = 1'b0;
        endcase
      end
      6'h08: legal = 1'b1;
      6'h0C: begin legal = 1'b1; cmd = EXE_AND; sext = 1'b0; end
      6'h0D: begin legal = 1'b1; cmd = EXE_OR;  sext = 1'b0; end
      6'h0E: begin legal = 1'b1; cmd = EXE_XOR; sext = 1'b0; end
      6'h23: begin legal = 1'b1; dec_mr = 1'b1; end
      6'h2B: begin legal = 1'b1; dec_mw = 1'b1; dec_wb = 1'b0; uses_rt = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // wb_en is never set for dest 0, so a dest match here implies a nonzero source
  logic hz_rs, hz_rt, hazard;
  logic [31:0] rs_val, rt_val, imm_ext;

  assign hz_rs   = exe_valid && wb_en && (dest == rs_addr);
  assign hz_rt   = uses_rt && exe_valid && wb_en && (dest == rt_addr);
  assign imm_ext = sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};

`ifdef ISSUE_FWD_EN
  assign hazard = instr_valid && mem_r_en && (hz_rs || hz_rt);
  assign rs_val = hz_rs ? alu_fwd : rs_data;
  assign rt_val = hz_rt ? alu_fwd : rt_data;
`else
  assign hazard = instr_valid && (hz_rs || hz_rt);
  assign rs_val = rs_data;
  assign rt_val = rt_data;
`endif

  logic accept;
  assign stall  = rst && hazard && !flush;
  assign accept = instr_valid && !hazard && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_valid <= 1'b0;
      wb_en     <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      illegal   <= 1'b0;
      exe_cmd   <= '0;
      val1      <= '0;
      val2      <= '0;
      st_val    <= '0;
      dest      <= '0;
    end else begin
      illegal   <= illegal | (accept && !legal);
      exe_valid <= accept && legal;
      wb_en     <= accept && legal && dec_wb && (dec_dest != 5'd0);
      mem_r_en  <= accept && legal && dec_mr;
      mem_w_en  <= accept && legal && dec_mw;
      if (accept && legal) begin
        exe_cmd <= cmd;
        val1    <= rs_val;
        val2    <= imm_op ? imm_ext : rt_val;
        st_val  <= rt_val;
        dest    <= dec_dest;
      end
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - directed-vector bench for issue_stage (default and ISSUE_FWD_EN builds).
`timescale 1ns/1ps
module tb_issue_stage;
  localparam logic [3:0] C_ADD = 4'd1, C_SUB = 4'd2, C_OR = 4'd4;
  localparam logic [31:0] FWD_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0, flush = 1'b0, stall;
  logic [4:0]  rs_addr, rt_addr, dest;
  logic [31:0] rs_data, rt_data, val1, val2, st_val;
  logic [31:0] alu_fwd = FWD_VAL;
  logic [3:0]  exe_cmd;
  logic        exe_valid, wb_en, mem_r_en, mem_w_en, illegal;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (r == 5'd1) return 32'd10;
    return 32'h1000 + {27'd0, r};
  endfunction
  assign rs_data = rf(rs_addr);
  assign rt_data = rf(rt_addr);

  issue_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
`ifdef ISSUE_FWD_EN
    .alu_fwd(alu_fwd),
`endif
    .exe_valid(exe_valid), .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .st_val(st_val),
    .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] w, input logic v, input logic f);
    @(negedge clk);
    instr = w; instr_valid = v; flush = f;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a valid add presented
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0);
    tick();
    check("rst_exe_valid", exe_valid, 0); check("rst_wb_en", wb_en, 0);
    check("rst_mem_r", mem_r_en, 0);      check("rst_mem_w", mem_w_en, 0);
    check("rst_illegal", illegal, 0);     check("rst_cmd", exe_cmd, 0);
    check("rst_val1", val1, 0);           check("rst_val2", val2, 0);
    check("rst_st_val", st_val, 0);       check("rst_dest", dest, 0);
    rst = 1'b1;
    drive(32'd0, 1'b0, 1'b0);
    check("rst_stall", stall, 0);
    tick();
    check("idle_bubble", exe_valid, 0);

    // addi r2,r1,-4
    drive(itype(6'h08, 5'd1, 5'd2, 16'hFFFC), 1'b1, 1'b0);
    check("addi_stall", stall, 0);
    tick();
    check("addi_valid", exe_valid, 1); check("addi_cmd", exe_cmd, C_ADD);
    check("addi_val1", val1, 10);      check("addi_val2", val2, 32'hFFFF_FFFC);
    check("addi_dest", dest, 2);       check("addi_wb", wb_en, 1);

    // ori r6,r7,0x8000
    drive(itype(6'h0D, 5'd7, 5'd6, 16'h8000), 1'b1, 1'b0);
    tick();
    check("ori_cmd", exe_cmd, C_OR); check("ori_val2", val2, 32'h0000_8000);
    check("ori_val1", val1, 32'h1007);

    // lw r3,0(r1) then add r4,r3,r5: one stall, one bubble
    drive(itype(6'h23, 5'd1, 5'd3, 16'h0000), 1'b1, 1'b0);
    tick();
    check("lw_mem_r", mem_r_en, 1); check("lw_wb", wb_en, 1); check("lw_dest", dest, 3);
    drive(rtype(5'd3, 5'd5, 5'd4, 6'h20), 1'b1, 1'b0);
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble", exe_valid, 0); check("lu_bubble_wb", wb_en, 0);
    drive(rtype(5'd3, 5'd5, 5'd4, 6'h20), 1'b1, 1'b0);
    check("lu_stall_once", stall, 0);
    tick();
    check("lu_add_valid", exe_valid, 1); check("lu_add_val1", val1, 32'h1003);
    check("lu_add_val2", val2, 32'h1005); check("lu_add_dest", dest, 4);

    // add r3,r1,r2 then sub r4,r3,r1
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0);
    tick();
    check("dep_add_valid", exe_valid, 1);
    drive(rtype(5'd3, 5'd1, 5'd4, 6'h22), 1'b1, 1'b0);
`ifdef ISSUE_FWD_EN
    check("dep_stall", stall, 0);
    tick();
    check("dep_sub_val1", val1, FWD_VAL);
`else
    check("dep_stall", stall, 1);
    tick();
    check("dep_bubble", exe_valid, 0);
    drive(rtype(5'd3, 5'd1, 5'd4, 6'h22), 1'b1, 1'b0);
    check("dep_stall_once", stall, 0);
    tick();
    check("dep_sub_val1", val1, 32'h1003);
`endif
    check("dep_sub_cmd", exe_cmd, C_SUB); check("dep_sub_val2", val2, 10);
    check("dep_sub_valid", exe_valid, 1);

    // flush with add r5,r4,r1 while sub r4 sits in EXE
    drive(rtype(5'd4, 5'd1, 5'd5, 6'h20), 1'b1, 1'b1);
    check("flush_stall", stall, 0);
    tick();
    check("flush_bubble", exe_valid, 0); check("flush_wb", wb_en, 0);
    drive(rtype(5'd1, 5'd2, 5'd7, 6'h20), 1'b1, 1'b0);
    tick();
    check("post_flush_dest", dest, 7); check("post_flush_valid", exe_valid, 1);

    // illegal opcode 0x3F is sticky until reset
    drive(itype(6'h3F, 5'd1, 5'd2, 16'h0001), 1'b1, 1'b0);
    tick();
    check("ill_bubble", exe_valid, 0); check("ill_flag", illegal, 1);
    drive(itype(6'h08, 5'd1, 5'd2, 16'h0001), 1'b1, 1'b0);
    tick();
    check("ill_legal_valid", exe_valid, 1); check("ill_sticky", illegal, 1);
    check("ill_legal_val2", val2, 1);
    drive(itype(6'h08, 5'd1, 5'd2, 16'h0001), 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    check("ill_cleared", illegal, 0); check("ill_rst_valid", exe_valid, 0);
    rst = 1'b1;

    // register 0 destination
    drive(rtype(5'd1, 5'd2, 5'd0, 6'h20), 1'b1, 1'b0);
    check("r0_post_rst_stall", stall, 0);
    tick();
    check("r0_valid", exe_valid, 1); check("r0_wb", wb_en, 0);
    drive(rtype(5'd0, 5'd1, 5'd5, 6'h20), 1'b1, 1'b0);
    check("r0_no_hazard", stall, 0);
    tick();
    check("r0_next_valid", exe_valid, 1); check("r0_next_val1", val1, 0);
    check("r0_next_val2", val2, 10); check("r0_next_wb", wb_en, 1);

    // sw r6,8(r1)
    drive(itype(6'h2B, 5'd1, 5'd6, 16'h0008), 1'b1, 1'b0);
    tick();
    check("sw_mem_w", mem_w_en, 1); check("sw_wb", wb_en, 0);
    check("sw_st_val", st_val, 32'h1006); check("sw_val2", val2, 8);

    drive(32'd0, 1'b0, 1'b0);
    tick();
    check("invalid_bubble", exe_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
